// File: rtl/qpsk_demodulator.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_demodulator
//  Description : Hard-decision QPSK slicer with low-confidence flag and a
//                four-symbol byte packer.
//                Each accepted I/Q pair is sliced on its sign bits into a
//                dibit {I_bit, Q_bit}. Zero counts as positive. A symbol is
//                flagged low-confidence when either |I| or |Q| is below
//                THRESH. Four consecutive dibits are packed MSB-first into
//                a byte.
//  Ports       : clk        - system clock, rising edge
//                reset      - asynchronous reset, active low
//                in_valid   - I_in/Q_in carry a symbol this cycle
//                I_in, Q_in - signed two's-complement samples, WIDTH bits
//                data_out   - decided dibit {I_bit, Q_bit}
//                out_valid  - one-cycle strobe per decided symbol
//                low_conf   - symbol was close to a decision boundary
//                byte_out   - four packed dibits, first symbol in [7:6]
//                byte_valid - one-cycle strobe per completed byte
//  Revision    : 1.0 - initial release
// ============================================================================
module qpsk_demodulator #(
    parameter int          WIDTH  = 16,
    parameter int unsigned THRESH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] I_in,
    input  logic [WIDTH-1:0] Q_in,
    output logic [1:0]       data_out,
    output logic             out_valid,
    output logic             low_conf,
    output logic [7:0]       byte_out,
    output logic             byte_valid
);

    // Threshold held at magnitude width so the compare is a plain unsigned
    // compare of equal-width operands.
    localparam logic [WIDTH:0] c_thresh = (WIDTH+1)'(THRESH);

    logic [WIDTH:0] w_i_ext;
    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_i_mag;
    logic [WIDTH:0] w_q_mag;
    logic [1:0]     w_dibit;
    logic           w_low_conf;
    logic [7:0]     w_packed;

    logic [1:0]     r_data;
    logic           r_out_valid;
    logic           r_low_conf;
    logic [7:0]     r_byte;
    logic           r_byte_valid;
    logic [1:0]     r_idx;
    // Only the upper three slots need storage; slot 3 goes straight to
    // byte_out at completion.
    logic [7:2]     r_partial;

    // Sign-extend by one bit so negating the most negative sample yields
    // 2^(WIDTH-1) instead of wrapping.
    assign w_i_ext = {I_in[WIDTH-1], I_in};
    assign w_q_ext = {Q_in[WIDTH-1], Q_in};
    assign w_i_mag = I_in[WIDTH-1] ? -w_i_ext : w_i_ext;
    assign w_q_mag = Q_in[WIDTH-1] ? -w_q_ext : w_q_ext;

    assign w_dibit    = {~I_in[WIDTH-1], ~Q_in[WIDTH-1]};
    assign w_low_conf = (w_i_mag < c_thresh) || (w_q_mag < c_thresh);

    // Insert the current dibit into its slot of the byte under construction.
    always_comb begin
        w_packed = {r_partial, 2'b00};
        case (r_idx)
            2'd0:    w_packed[7:6] = w_dibit;
            2'd1:    w_packed[5:4] = w_dibit;
            2'd2:    w_packed[3:2] = w_dibit;
            default: w_packed[1:0] = w_dibit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data       <= 2'b00;
            r_out_valid  <= 1'b0;
            r_low_conf   <= 1'b0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_idx        <= 2'd0;
            r_partial    <= 6'd0;
        end else begin
            r_out_valid  <= in_valid;
            r_byte_valid <= 1'b0;
            if (in_valid) begin
                r_data     <= w_dibit;
                r_low_conf <= w_low_conf;
                r_idx      <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_byte       <= w_packed;
                    r_byte_valid <= 1'b1;
                    r_partial    <= 6'd0;
                end else begin
                    r_partial    <= w_packed[7:2];
                end
            end
        end
    end

    assign data_out   = r_data;
    assign out_valid  = r_out_valid;
    assign low_conf   = r_low_conf;
    assign byte_out   = r_byte;
    assign byte_valid = r_byte_valid;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_demodulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qpsk_demodulator
//  Description : Self-checking bench for qpsk_demodulator. Two instances share
//                the stimulus: one with THRESH = 2, one with THRESH = 0
//                (low_conf must stay 0). Expected symbols and bytes are
//                queued when driven and compared when the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_demodulator;

    localparam int c_width = 16;

    typedef struct packed {
        logic [1:0] dibit;
        logic       lc;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [c_width-1:0]  i_in;
    logic [c_width-1:0]  q_in;

    logic [1:0] data_out,  data_out0;
    logic       out_valid, out_valid0;
    logic       low_conf,  low_conf0;
    logic [7:0] byte_out,  byte_out0;
    logic       byte_valid, byte_valid0;

    int n_checks;
    int n_fail;

    exp_t       sb_q[$];
    logic [7:0] byte_q[$];
    int         m_idx;
    logic [7:0] m_acc;

    qpsk_demodulator #(.WIDTH(c_width), .THRESH(2)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid),
        .I_in(i_in), .Q_in(q_in),
        .data_out(data_out), .out_valid(out_valid), .low_conf(low_conf),
        .byte_out(byte_out), .byte_valid(byte_valid)
    );

    qpsk_demodulator #(.WIDTH(c_width), .THRESH(0)) dut0 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid),
        .I_in(i_in), .Q_in(q_in),
        .data_out(data_out0), .out_valid(out_valid0), .low_conf(low_conf0),
        .byte_out(byte_out0), .byte_valid(byte_valid0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one symbol for one cycle and queue what the spec says it decodes to.
    task automatic drive_sym(input logic [15:0] iv, input logic [15:0] qv);
        int   ai, aq;
        exp_t e;
        ai = $signed(iv);
        aq = $signed(qv);
        if (ai < 0) ai = -ai;
        if (aq < 0) aq = -aq;
        e.dibit = {~iv[15], ~qv[15]};
        e.lc    = (ai < 2) || (aq < 2);
        sb_q.push_back(e);
        m_acc[7-2*m_idx -: 2] = e.dibit;
        if (m_idx == 3) begin
            byte_q.push_back(m_acc);
            m_idx = 0;
            m_acc = 8'h00;
        end else begin
            m_idx++;
        end
        in_valid = 1'b1;
        i_in     = iv;
        q_in     = qv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},  {30'd0, data_out},  32'd0);
        check_eq({tag, "_ov"},    {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_lc"},    {31'd0, low_conf},  32'd0);
        check_eq({tag, "_byte"},  {24'd0, byte_out},  32'd0);
        check_eq({tag, "_bv"},    {31'd0, byte_valid}, 32'd0);
        check_eq({tag, "_ov0"},   {31'd0, out_valid0}, 32'd0);
        check_eq({tag, "_bv0"},   {31'd0, byte_valid0}, 32'd0);
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check_eq("ov_match", {31'd0, out_valid0}, {31'd0, out_valid});
            check_eq("lc_thresh0", {31'd0, low_conf0}, 32'd0);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("data_out",  {30'd0, data_out},  {30'd0, e.dibit});
                    check_eq("data_out0", {30'd0, data_out0}, {30'd0, e.dibit});
                    check_eq("low_conf",  {31'd0, low_conf},  {31'd0, e.lc});
                end
            end
            if (byte_valid) begin
                check_eq("bv_with_ov", {31'd0, out_valid}, 32'd1);
                if (byte_q.size() == 0) begin
                    check_eq("unexpected_byte_valid", 32'd1, 32'd0);
                end else begin
                    logic [7:0] b;
                    b = byte_q.pop_front();
                    check_eq("byte_out",  {24'd0, byte_out},  {24'd0, b});
                    check_eq("byte_out0", {24'd0, byte_out0}, {24'd0, b});
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_idx    = 0;
        m_acc    = 8'h00;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        i_in     = 16'h7FFF;
        q_in     = 16'h7FFF;

        // Reset held with traffic present: nothing may come out.
        @(posedge clk); #1;
        check_all_zero("rst1");
        @(posedge clk); #1;
        check_all_zero("rst2");
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Four quadrants back to back -> 00,10,01,11 and byte 0x27.
        drive_sym(16'h8000, 16'h8000);
        drive_sym(16'h0001, 16'h8000);
        drive_sym(16'h8000, 16'h0001);
        drive_sym(16'h0001, 16'h0001);
        idle(2);
        check_eq("byte_hold", {24'd0, byte_out}, 32'h27);
        check_eq("bv_idle",   {31'd0, byte_valid}, 32'd0);

        // Zero / boundary / threshold cases, forming one byte 0xB3.
        drive_sym(16'h0000, 16'hFFFF);
        drive_sym(16'h0001, 16'h7FFF);
        drive_sym(16'h8000, 16'hFFFE);
        drive_sym(16'h7FFF, 16'h7FFF);
        idle(2);

        // Quadrants again with idle gaps of varying length.
        drive_sym(16'h8000, 16'h8000);
        idle(1);
        drive_sym(16'h0001, 16'h8000);
        idle(3);
        drive_sym(16'h8000, 16'h0001);
        idle(2);
        drive_sym(16'h0001, 16'h0001);
        idle(2);
        check_eq("gap_byte", {24'd0, byte_out}, 32'h27);

        // Reset mid-byte discards the partial group.
        drive_sym(16'h8000, 16'h8000);
        drive_sym(16'h0001, 16'h0001);
        idle(2);
        #2 rst_n = 1'b0;
        m_idx = 0;
        m_acc = 8'h00;
        @(negedge clk);
        check_all_zero("rst_mid");
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) drive_sym(16'h7FFF, 16'h0100);
        idle(3);
        check_eq("post_rst_byte", {24'd0, byte_out}, 32'hFF);

        check_eq("sb_drained",   sb_q.size(),   32'd0);
        check_eq("byte_drained", byte_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
